// File: rtl/rv32i_core.sv
// Single-cycle RV32I core with a unified word-addressed memory and a 32-entry register file.
// ECALL/EBREAK freeze the core until reset; only clk and rst_n cross the boundary.

module rv32i_regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] data [0:31];

  // NOTE: storage arrays carry no reset; they are preloaded from outside and a reset loop would block RAM mapping.
  always_ff @(posedge clk) begin
    if (we && waddr != 5'd0) data[waddr] <= wdata;
  end

  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : data[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : data[raddr2];
endmodule

module rv32i_core #(
  parameter int unsigned MEM_WORDS = 16384,
  parameter logic [31:0] RESET_PC  = 32'h8000_0000
) (
  input logic clk,
  input logic rst_n
);
  localparam int          AW     = $clog2(MEM_WORDS);
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [6:0] {
    OP_LUI    = 7'h37,
    OP_AUIPC  = 7'h17,
    OP_JAL    = 7'h6F,
    OP_JALR   = 7'h67,
    OP_BRANCH = 7'h63,
    OP_LOAD   = 7'h03,
    OP_STORE  = 7'h23,
    OP_IMM    = 7'h13,
    OP_REG    = 7'h33,
    OP_SYSTEM = 7'h73
  } opcode_e;

  logic [31:0] mem [0:MEM_WORDS-1];

  logic [31:0] pc, next_pc, instr;
  logic        halted, halt_now, commit, is_ecall;
  opcode_e     opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;
  logic        rd_we;
  logic [31:0] rd_data;
  logic [31:0] data_addr, load_word, load_data;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic        store_en;
  logic [3:0]  store_be;
  logic [31:0] store_data;
  logic        branch_taken;
  logic        unused_bits;

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] y;
    y = 32'd0;
    case (f3)
      3'b000: y = alt ? a - b : a + b;
      3'b001: y = a << b[4:0];
      3'b010: y = {31'd0, $signed(a) < $signed(b)};
      3'b011: y = {31'd0, a < b};
      3'b100: y = a ^ b;
      3'b101: if (alt) y = $unsigned($signed(a) >>> b[4:0]);
              else     y = a >> b[4:0];
      3'b110: y = a | b;
      3'b111: y = a & b;
      default: y = 32'd0;
    endcase
    return y;
  endfunction

  assign instr  = mem[pc[AW+1:2]];
  assign opcode = opcode_e'(instr[6:0]);
  assign funct3 = instr[14:12];
  assign rd     = instr[11:7];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'd0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  rv32i_regfile i_regfile (
    .clk    (clk),
    .we     (rd_we & commit),
    .waddr  (rd),
    .wdata  (rd_data),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val)
  );

  // A halting instruction retires nothing; the core just parks on it.
  assign halt_now = (instr == ECALL) || (instr == EBREAK);
  assign commit   = !rst_n && !halted && !halt_now;
  assign is_ecall = !rst_n && (instr == ECALL);

  assign data_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign load_word = mem[data_addr[AW+1:2]];
  assign load_byte = load_word[{data_addr[1:0], 3'b000} +: 8];
  assign load_half = data_addr[1] ? load_word[31:16] : load_word[15:0];

  always_comb begin
    load_data = load_word;
    case (funct3)
      3'b000: load_data = {{24{load_byte[7]}}, load_byte};
      3'b001: load_data = {{16{load_half[15]}}, load_half};
      3'b100: load_data = {24'd0, load_byte};
      3'b101: load_data = {16'd0, load_half};
      default: load_data = load_word;
    endcase
  end

  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      3'b000: branch_taken = (rs1_val == rs2_val);
      3'b001: branch_taken = (rs1_val != rs2_val);
      3'b100: branch_taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101: branch_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110: branch_taken = (rs1_val <  rs2_val);
      3'b111: branch_taken = (rs1_val >= rs2_val);
      default: branch_taken = 1'b0;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    next_pc    = pc + 32'd4;
    rd_we      = 1'b0;
    rd_data    = 32'd0;
    store_en   = 1'b0;
    store_be   = 4'b0000;
    store_data = 32'd0;
    case (opcode)
      OP_LUI: begin
        rd_we   = 1'b1;
        rd_data = imm_u;
      end
      OP_AUIPC: begin
        rd_we   = 1'b1;
        rd_data = pc + imm_u;
      end
      OP_JAL: begin
        rd_we   = 1'b1;
        rd_data = pc + 32'd4;
        next_pc = pc + imm_j;
      end
      OP_JALR: begin
        rd_we   = 1'b1;
        rd_data = pc + 32'd4;
        next_pc = (rs1_val + imm_i) & ~32'd1;
      end
      OP_BRANCH: if (branch_taken) next_pc = pc + imm_b;
      OP_LOAD: begin
        rd_we   = 1'b1;
        rd_data = load_data;
      end
      OP_STORE: begin
        store_en = 1'b1;
        case (funct3)
          3'b000: begin
            store_be   = 4'b0001 << data_addr[1:0];
            store_data = {4{rs2_val[7:0]}};
          end
          3'b001: begin
            store_be   = data_addr[1] ? 4'b1100 : 4'b0011;
            store_data = {2{rs2_val[15:0]}};
          end
          default: begin
            store_be   = 4'b1111;
            store_data = rs2_val;
          end
        endcase
      end
      OP_IMM: begin
        rd_we   = 1'b1;
        rd_data = alu(funct3, (funct3 == 3'b101) && instr[30], rs1_val, imm_i);
      end
      OP_REG: begin
        rd_we   = 1'b1;
        rd_data = alu(funct3, instr[30], rs1_val, rs2_val);
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      pc     <= RESET_PC;
      halted <= 1'b0;
    end else if (!halted) begin
      if (halt_now) halted <= 1'b1;
      else          pc     <= next_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (store_en && commit) begin
      for (int b = 0; b < 4; b++) begin
        if (store_be[b]) mem[data_addr[AW+1:2]][8*b +: 8] <= store_data[8*b +: 8];
      end
    end
  end

  // Upper address bits alias by design; is_ecall is observed from outside by name.
  assign unused_bits = ^{pc[31:AW+2], pc[1:0], data_addr[31:AW+2], is_ecall};
endmodule

// File: tb/tb_rv32i_core.sv
// Scoreboard bench for rv32i_core: programs are loaded through hierarchy, expected state is queued
// at issue time, and a monitor compares it once the core parks on ECALL.

module tb_rv32i_core;
  localparam logic [31:0] RESET_PC  = 32'h8000_0000;
  localparam logic [31:0] ECALL     = 32'h0000_0073;
  localparam int          MEM_WORDS = 16384;
  localparam int          BUDGET    = 500;
  localparam int          DBASE     = 128;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rv32i_core #(.MEM_WORDS(MEM_WORDS), .RESET_PC(RESET_PC)) dut (.clk(clk), .rst_n(rst_n));

  typedef enum {K_REG, K_MEM, K_CYC, K_PC, K_END} kind_e;
  typedef struct {
    kind_e       kind;
    string       name;
    int          idx;
    logic [31:0] val;
  } exp_t;
  typedef enum {A_ADD, A_SUB, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_SRA, A_OR, A_AND} aop_e;

  exp_t        sb_q[$];
  logic [31:0] prog[$];
  int          n_pass  = 0;
  int          n_total = 0;
  bit          armed   = 1'b0;
  int          cyc     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h, expected %08h", name, act, exp);
  endtask

  function automatic void expect_item(kind_e k, string name, int idx, logic [31:0] val);
    exp_t e;
    e.kind = k; e.name = name; e.idx = idx; e.val = val;
    sb_q.push_back(e);
  endfunction

  // Instruction encoders
  function automatic logic [31:0] enc_i(logic [31:0] imm, int rs1, int f3, int rd, logic [6:0] op);
    return {imm[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction
  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(logic [31:0] imm, int rs2, int rs1, int f3);
    return {imm[11:5], 5'(rs2), 5'(rs1), 3'(f3), imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(logic [31:0] imm, int rs2, int rs1, int f3);
    return {imm[12], imm[10:5], 5'(rs2), 5'(rs1), 3'(f3), imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(logic [31:0] imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'(rd), 7'h6F};
  endfunction
  function automatic logic [31:0] enc_u(logic [31:0] imm20, int rd, logic [6:0] op);
    return {imm20[19:0], 5'(rd), op};
  endfunction

  function automatic int aop_f3(aop_e op);
    case (op)
      A_ADD, A_SUB: return 0;
      A_SLL:        return 1;
      A_SLT:        return 2;
      A_SLTU:       return 3;
      A_XOR:        return 4;
      A_SRL, A_SRA: return 5;
      A_OR:         return 6;
      default:      return 7;
    endcase
  endfunction

  // Reference arithmetic, straight from the mnemonic meanings.
  function automatic logic [31:0] ref_alu(aop_e op, logic [31:0] a, logic [31:0] b);
    int unsigned sh;
    sh = b % 32;
    case (op)
      A_ADD:  return a + b;
      A_SUB:  return a - b;
      A_SLL:  return a << sh;
      A_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      A_SLTU: return (a < b) ? 32'd1 : 32'd0;
      A_XOR:  return a ^ b;
      A_SRL:  return a >> sh;
      A_SRA:  return $signed(a) >>> sh;
      A_OR:   return a | b;
      default: return a & b;
    endcase
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (armed) begin
        if (dut.is_ecall === 1'b1 || cyc >= BUDGET) begin
          if (dut.is_ecall !== 1'b1) check("ecall_seen", 32'd0, 32'd1);
          while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            if (e.kind == K_END) break;
            case (e.kind)
              K_REG:   check(e.name, dut.i_regfile.data[e.idx], e.val);
              K_MEM:   check(e.name, dut.mem[e.idx], e.val);
              K_CYC:   check(e.name, 32'(cyc), e.val);
              default: check(e.name, dut.pc, e.val);
            endcase
          end
          armed = 1'b0;
        end else begin
          cyc++;
        end
      end
    end
  end

  task automatic begin_test();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < MEM_WORDS; i++) dut.mem[i] = 32'd0;
    for (int i = 0; i < 32; i++) dut.i_regfile.data[i] = 32'd0;
    prog.delete();
  endtask

  task automatic load_prog();
    foreach (prog[i]) dut.mem[i] = prog[i];
  endtask

  task automatic run_test();
    cyc   = 0;
    armed = 1'b1;
    rst_n = 1'b0;
    wait (!armed);
  endtask

  function automatic void expect_end(string tag, int n_instr, int ecall_idx);
    expect_item(K_CYC, {tag, "_cycles"}, 0, 32'(n_instr));
    expect_item(K_PC, {tag, "_pc"}, 0, RESET_PC + 32'(4 * ecall_idx));
    expect_item(K_END, "", 0, 32'd0);
  endfunction

  task automatic random_test(input int t, input int n);
    logic [31:0] r [32];
    logic [7:0]  mb [64];
    logic [31:0] pc, res, b, u;
    logic [11:0] i12;
    aop_e        op;
    int          kind, rd, rs1, rs2, off, sz, h, w, sh;
    bit          wr;
    string       tag;
    tag = $sformatf("rnd%0d", t);
    for (int i = 0; i < 32; i++) r[i] = 32'd0;
    for (int i = 1; i < 8; i++) r[i] = $urandom;
    r[8] = ($urandom & 32'hFFFF_0000) | 32'h0000_0200;
    for (int i = 0; i < 64; i++) mb[i] = 8'($urandom);
    for (int i = 0; i < 32; i++) dut.i_regfile.data[i] = r[i];
    for (int i = 0; i < 16; i++) dut.mem[DBASE+i] = {mb[4*i+3], mb[4*i+2], mb[4*i+1], mb[4*i]};
    pc = RESET_PC;
    for (int k = 0; k < n; k++) begin
      kind = $urandom_range(0, 5);
      rd   = $urandom_range(0, 7);
      rs1  = $urandom_range(0, 8);
      rs2  = $urandom_range(0, 8);
      wr   = 1'b1;
      res  = 32'd0;
      case (kind)
        0: begin
          op = aop_e'($urandom_range(0, 9));
          prog.push_back(enc_r((op == A_SUB || op == A_SRA) ? 32 : 0, rs2, rs1, aop_f3(op), rd));
          res = ref_alu(op, r[rs1], r[rs2]);
        end
        1: begin
          op = aop_e'($urandom_range(0, 9));
          if (op == A_SUB) op = A_ADD;
          if (op == A_SLL || op == A_SRL || op == A_SRA) begin
            sh = $urandom_range(0, 31);
            b  = 32'(sh);
            prog.push_back(enc_i(32'(sh) | ((op == A_SRA) ? 32'h400 : 32'h0), rs1, aop_f3(op), rd, 7'h13));
          end else begin
            i12 = 12'($urandom);
            b   = {{20{i12[11]}}, i12};
            prog.push_back(enc_i(b, rs1, aop_f3(op), rd, 7'h13));
          end
          res = ref_alu(op, r[rs1], b);
        end
        2: begin
          off = $urandom_range(0, 63);
          sz  = $urandom_range(0, 4);
          h   = off & ~1;
          w   = off & ~3;
          case (sz)
            0: res = {{24{mb[off][7]}}, mb[off]};
            1: res = {{16{mb[h+1][7]}}, mb[h+1], mb[h]};
            2: res = {mb[w+3], mb[w+2], mb[w+1], mb[w]};
            3: res = {24'd0, mb[off]};
            default: res = {16'd0, mb[h+1], mb[h]};
          endcase
          prog.push_back(enc_i(32'(off), 8, (sz >= 3) ? sz + 1 : sz, rd, 7'h03));
        end
        3: begin
          off = $urandom_range(0, 63);
          sz  = $urandom_range(0, 2);
          rs2 = $urandom_range(0, 7);
          h   = off & ~1;
          w   = off & ~3;
          wr  = 1'b0;
          case (sz)
            0: mb[off] = r[rs2][7:0];
            1: begin
              mb[h] = r[rs2][7:0]; mb[h+1] = r[rs2][15:8];
            end
            default: for (int i = 0; i < 4; i++) mb[w+i] = r[rs2][8*i +: 8];
          endcase
          prog.push_back(enc_s(32'(off), rs2, 8, sz));
        end
        4: begin
          u   = $urandom;
          res = {u[31:12], 12'd0};
          prog.push_back(enc_u({12'd0, u[31:12]}, rd, 7'h37));
        end
        default: begin
          u   = $urandom;
          res = pc + {u[31:12], 12'd0};
          prog.push_back(enc_u({12'd0, u[31:12]}, rd, 7'h17));
        end
      endcase
      if (wr && rd != 0) r[rd] = res;
      pc = pc + 32'd4;
    end
    prog.push_back(ECALL);
    load_prog();
    for (int i = 0; i <= 8; i++) expect_item(K_REG, $sformatf("%s_x%0d", tag, i), i, r[i]);
    for (int i = 0; i < 16; i++)
      expect_item(K_MEM, $sformatf("%s_mem%0d", tag, i), DBASE + i,
                  {mb[4*i+3], mb[4*i+2], mb[4*i+1], mb[4*i]});
    expect_end(tag, n, n);
    run_test();
  endtask

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    rst_n = 1'b1;

    // Reset state and first program: addi x3,x0,1 ; ecall
    begin_test();
    check("reset_pc", dut.pc, RESET_PC);
    check("reset_is_ecall", 32'(dut.is_ecall), 32'd0);
    prog.push_back(32'h0010_0193);
    prog.push_back(ECALL);
    load_prog();
    expect_item(K_REG, "t1_x3", 3, 32'd1);
    expect_end("t1", 1, 1);
    run_test();
    repeat (4) @(negedge clk);
    check("t1_ecall_hold", 32'(dut.is_ecall), 32'd1);
    check("t1_pc_hold", dut.pc, RESET_PC + 32'd4);
    check("t1_x3_hold", dut.i_regfile.data[3], 32'd1);

    // Immediate arithmetic and shifts
    begin_test();
    prog.push_back(enc_i(-1, 0, 0, 1, 7'h13));
    prog.push_back(enc_i(28, 1, 5, 2, 7'h13));
    prog.push_back(enc_i(32'h404, 1, 5, 4, 7'h13));
    prog.push_back(enc_r(0, 1, 0, 3, 5));
    prog.push_back(ECALL);
    load_prog();
    expect_item(K_REG, "t2_x1", 1, 32'hFFFF_FFFF);
    expect_item(K_REG, "t2_srli", 2, 32'h0000_000F);
    expect_item(K_REG, "t2_srai", 4, 32'hFFFF_FFFF);
    expect_item(K_REG, "t2_sltu", 5, 32'd1);
    expect_end("t2", 4, 4);
    run_test();

    // Loads and stores of every width, including lane selection and misaligned word access
    begin_test();
    prog.push_back(enc_u(32'h80000, 1, 7'h37));
    prog.push_back(enc_i(32'h100, 1, 0, 1, 7'h13));
    prog.push_back(enc_i(32'hA5, 0, 0, 2, 7'h13));
    prog.push_back(enc_s(1, 2, 1, 0));
    prog.push_back(enc_i(1, 1, 0, 3, 7'h03));
    prog.push_back(enc_i(1, 1, 4, 4, 7'h03));
    prog.push_back(enc_i(-2, 0, 0, 5, 7'h13));
    prog.push_back(enc_s(2, 5, 1, 1));
    prog.push_back(enc_i(2, 1, 1, 6, 7'h03));
    prog.push_back(enc_i(2, 1, 5, 7, 7'h03));
    prog.push_back(enc_s(4, 5, 1, 2));
    prog.push_back(enc_i(6, 1, 2, 8, 7'h03));
    prog.push_back(ECALL);
    load_prog();
    dut.mem[64] = 32'h1122_3344;
    expect_item(K_REG, "t3_x1", 1, 32'h8000_0100);
    expect_item(K_REG, "t3_lb", 3, 32'hFFFF_FFA5);
    expect_item(K_REG, "t3_lbu", 4, 32'h0000_00A5);
    expect_item(K_REG, "t3_lh", 6, 32'hFFFF_FFFE);
    expect_item(K_REG, "t3_lhu", 7, 32'h0000_FFFE);
    expect_item(K_REG, "t3_lw_misaligned", 8, 32'hFFFF_FFFE);
    expect_item(K_MEM, "t3_mem64", 64, 32'hFFFE_A544);
    expect_item(K_MEM, "t3_mem65", 65, 32'hFFFF_FFFE);
    expect_end("t3", 12, 12);
    run_test();

    // Control flow: every branch kind taken or not, JAL link, JALR with odd target
    begin_test();
    prog.push_back(enc_b(8, 0, 0, 0));
    prog.push_back(enc_i(1, 0, 0, 10, 7'h13));
    prog.push_back(enc_j(12, 1));
    prog.push_back(enc_i(1, 0, 0, 11, 7'h13));
    prog.push_back(enc_i(1, 0, 0, 12, 7'h13));
    prog.push_back(enc_u(0, 5, 7'h17));
    prog.push_back(enc_i(17, 5, 0, 5, 7'h13));
    prog.push_back(enc_i(0, 5, 0, 6, 7'h67));
    prog.push_back(enc_i(1, 0, 0, 13, 7'h13));
    prog.push_back(enc_b(8, 0, 0, 1));
    prog.push_back(enc_i(-1, 0, 0, 7, 7'h13));
    prog.push_back(enc_b(8, 0, 7, 4));
    prog.push_back(enc_i(1, 0, 0, 14, 7'h13));
    prog.push_back(enc_b(8, 7, 0, 7));
    prog.push_back(enc_b(8, 7, 0, 6));
    prog.push_back(enc_i(1, 0, 0, 15, 7'h13));
    prog.push_back(enc_b(8, 0, 7, 5));
    prog.push_back(ECALL);
    load_prog();
    expect_item(K_REG, "t4_jal_link", 1, 32'h8000_000C);
    expect_item(K_REG, "t4_x5", 5, 32'h8000_0025);
    expect_item(K_REG, "t4_jalr_link", 6, 32'h8000_0020);
    expect_item(K_REG, "t4_x7", 7, 32'hFFFF_FFFF);
    for (int i = 10; i <= 15; i++) expect_item(K_REG, $sformatf("t4_skipped_x%0d", i), i, 32'd0);
    expect_end("t4", 11, 17);
    run_test();

    // Writes to x0 are discarded
    begin_test();
    dut.i_regfile.data[6] = 32'h1234_5678;
    prog.push_back(enc_i(5, 0, 0, 0, 7'h13));
    prog.push_back(enc_r(0, 0, 0, 0, 6));
    prog.push_back(ECALL);
    load_prog();
    expect_item(K_REG, "t5_x0", 0, 32'd0);
    expect_item(K_REG, "t5_x6", 6, 32'd0);
    expect_end("t5", 2, 2);
    run_test();

    // Long reset while halted on ECALL, with the program replaced under reset
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("t6_reset_is_ecall%0d", c), 32'(dut.is_ecall), 32'd0);
    end
    check("t6_reset_pc", dut.pc, RESET_PC);
    @(posedge clk); #1;
    dut.mem[0] = enc_i(7, 0, 0, 3, 7'h13);
    dut.mem[1] = ECALL;
    dut.i_regfile.data[3] = 32'd0;
    expect_item(K_REG, "t6_x3", 3, 32'd7);
    expect_end("t6", 1, 1);
    run_test();

    // Reset in the middle of a store loop suppresses that cycle's writes
    begin_test();
    dut.i_regfile.data[8] = 32'h8000_0200;
    prog.push_back(enc_i(1, 1, 0, 1, 7'h13));
    prog.push_back(enc_s(0, 1, 8, 2));
    prog.push_back(enc_j(-8, 0));
    load_prog();
    rst_n = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t7_x1", dut.i_regfile.data[1], 32'd3);
    check("t7_mem", dut.mem[DBASE], 32'd2);
    check("t7_pc", dut.pc, RESET_PC);

    for (int t = 0; t < 20; t++) begin
      begin_test();
      random_test(t, 24);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
